// File: rtl/pwl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwl_pkg
// Description : Shared fixed-point constants, types and FSM encoding for the
//               piece-wise linear jerk-system Euler integrator.
// Revision    : 1.0 - initial release
// ============================================================================
package pwl_pkg;

   localparam int FIX_W   = 16;
   localparam int CNT_W   = 16;
   localparam int FRAC    = 13;
   localparam int SHIFT_H = 6;

   typedef logic signed [FIX_W-1:0] fix_t;

   localparam fix_t ONE    = 16'sd8192;
   localparam fix_t COEF_A = 16'sd4915;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_DERIV  = 2'd2,
      S_UPDATE = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/pwl_euler_integrator_sat_add.sv
`default_nettype none
// ============================================================================
// Module      : sat_add
// Description : Signed adder of two IN_W-bit operands, clamped to a signed
//               WIDTH-bit result (IN_W >= WIDTH).
// Revision    : 1.0 - initial release
// ============================================================================
module sat_add #(
   parameter int IN_W  = 16,
   parameter int WIDTH = 16
) (
   input  logic [IN_W-1:0]  i_a,
   input  logic [IN_W-1:0]  i_b,
   output logic [WIDTH-1:0] o_sum
);

   localparam int GUARD = IN_W + 1 - WIDTH;
   localparam logic signed [IN_W:0] c_MAX = {{GUARD{1'b0}}, 1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [IN_W:0] c_MIN = {{GUARD{1'b1}}, 1'b1, {(WIDTH-1){1'b0}}};

   logic signed [IN_W:0] w_sum;

   assign w_sum = $signed({i_a[IN_W-1], i_a}) + $signed({i_b[IN_W-1], i_b});

   always_comb begin
      o_sum = w_sum[WIDTH-1:0];
      if (w_sum > c_MAX) begin
         o_sum = {1'b0, {(WIDTH-1){1'b1}}};
      end else if (w_sum < c_MIN) begin
         o_sum = {1'b1, {(WIDTH-1){1'b0}}};
      end
   end

endmodule
`default_nettype wire

// File: rtl/pwl_euler_integrator.sv
`default_nettype none
// ============================================================================
// Module      : pwl_euler_integrator
// Description : Forward-Euler integrator of x'=y, y'=z, z'=-A*z-y+|x|-1 in
//               saturating Q2.13, one (x,y,z) sample every two cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pwl_euler_integrator #(
   parameter int                      WIDTH     = pwl_pkg::FIX_W,
   parameter int                      FRAC      = pwl_pkg::FRAC,
   parameter logic signed [WIDTH-1:0] COEF_A    = pwl_pkg::COEF_A,
   parameter int                      SHIFT_H   = pwl_pkg::SHIFT_H,
   parameter int                      CNT_WIDTH = pwl_pkg::CNT_W
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic [CNT_WIDTH-1:0] steps_i,
   input  logic [WIDTH-1:0]     x0_i,
   input  logic [WIDTH-1:0]     y0_i,
   input  logic [WIDTH-1:0]     z0_i,
   output logic [WIDTH-1:0]     x_o,
   output logic [WIDTH-1:0]     y_o,
   output logic [WIDTH-1:0]     z_o,
   output logic                 valid_o,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam int EXT_W = WIDTH + 3;
   localparam int GUARD = EXT_W - WIDTH;
   localparam logic signed [WIDTH-1:0] c_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] c_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic signed [EXT_W-1:0] c_ONE = EXT_W'(1 << FRAC);

   pwl_pkg::state_e             r_state;
   logic [CNT_WIDTH-1:0]        r_steps;
   logic [CNT_WIDTH-1:0]        r_cnt;
   logic signed [WIDTH-1:0]     r_x0, r_y0, r_z0;
   logic signed [WIDTH-1:0]     r_x, r_y, r_z;
   logic signed [WIDTH-1:0]     r_dx, r_dy, r_dz;
   logic                        r_valid;
   logic                        r_done;

   logic signed [2*WIDTH-1:0]   w_prod;
   logic signed [EXT_W-1:0]     w_az, w_y_ext, w_abs_ext, w_dz_a, w_dz_b;
   logic signed [WIDTH-1:0]     w_abs_x, w_dz;
   logic signed [WIDTH-1:0]     w_dx_h, w_dy_h, w_dz_h;
   logic signed [WIDTH-1:0]     w_x_nxt, w_y_nxt, w_z_nxt;

   // dz = -(A*z) - y + |x| - 1, split into two guard-width terms for one clamp
   assign w_prod    = r_z * COEF_A;
   assign w_az      = EXT_W'(w_prod >>> FRAC);
   assign w_abs_x   = (r_x == c_MIN) ? c_MAX : (r_x[WIDTH-1] ? -r_x : r_x);
   assign w_y_ext   = {{GUARD{r_y[WIDTH-1]}}, r_y};
   assign w_abs_ext = {{GUARD{1'b0}}, w_abs_x};
   assign w_dz_a    = -w_az - w_y_ext;
   assign w_dz_b    = w_abs_ext - c_ONE;

   sat_add #(.IN_W(EXT_W), .WIDTH(WIDTH)) u_sat_dz (
      .i_a   (w_dz_a),
      .i_b   (w_dz_b),
      .o_sum (w_dz)
   );

   assign w_dx_h = r_dx >>> SHIFT_H;
   assign w_dy_h = r_dy >>> SHIFT_H;
   assign w_dz_h = r_dz >>> SHIFT_H;

   sat_add #(.IN_W(WIDTH), .WIDTH(WIDTH)) u_sat_x (
      .i_a   (r_x),
      .i_b   (w_dx_h),
      .o_sum (w_x_nxt)
   );

   sat_add #(.IN_W(WIDTH), .WIDTH(WIDTH)) u_sat_y (
      .i_a   (r_y),
      .i_b   (w_dy_h),
      .o_sum (w_y_nxt)
   );

   sat_add #(.IN_W(WIDTH), .WIDTH(WIDTH)) u_sat_z (
      .i_a   (r_z),
      .i_b   (w_dz_h),
      .o_sum (w_z_nxt)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= pwl_pkg::S_IDLE;
         r_steps <= '0;
         r_cnt   <= '0;
         r_x0    <= '0;
         r_y0    <= '0;
         r_z0    <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_dx    <= '0;
         r_dy    <= '0;
         r_dz    <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            pwl_pkg::S_IDLE: begin
               if (start_i) begin
                  r_steps <= steps_i;
                  r_x0    <= x0_i;
                  r_y0    <= y0_i;
                  r_z0    <= z0_i;
                  r_state <= pwl_pkg::S_LOAD;
               end
            end
            pwl_pkg::S_LOAD: begin
               r_x   <= r_x0;
               r_y   <= r_y0;
               r_z   <= r_z0;
               r_cnt <= r_steps;
               if (r_steps == '0) begin
                  r_done  <= 1'b1;
                  r_state <= pwl_pkg::S_IDLE;
               end else begin
                  r_state <= pwl_pkg::S_DERIV;
               end
            end
            pwl_pkg::S_DERIV: begin
               r_dx    <= r_y;
               r_dy    <= r_z;
               r_dz    <= w_dz;
               r_state <= pwl_pkg::S_UPDATE;
            end
            pwl_pkg::S_UPDATE: begin
               r_x     <= w_x_nxt;
               r_y     <= w_y_nxt;
               r_z     <= w_z_nxt;
               r_valid <= 1'b1;
               r_cnt   <= r_cnt - 1'b1;
               if (r_cnt == CNT_WIDTH'(1)) begin
                  r_done  <= 1'b1;
                  r_state <= pwl_pkg::S_IDLE;
               end else begin
                  r_state <= pwl_pkg::S_DERIV;
               end
            end
            default: r_state <= pwl_pkg::S_IDLE;
         endcase
      end
   end

   assign x_o     = r_x;
   assign y_o     = r_y;
   assign z_o     = r_z;
   assign valid_o = r_valid;
   assign done_o  = r_done;
   assign busy_o  = (r_state != pwl_pkg::S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pwl_euler_integrator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwl_euler_integrator
// Description : Scoreboard bench for pwl_euler_integrator against an integer
//               floor/clamp model of the jerk-system Euler step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwl_euler_integrator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] steps = '0;
   logic [15:0] x0 = '0, y0 = '0, z0 = '0;
   logic [15:0] x_o, y_o, z_o;
   logic        valid_o, busy_o, done_o;

   pwl_euler_integrator dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .start_i (start),
      .steps_i (steps),
      .x0_i    (x0),
      .y0_i    (y0),
      .z0_i    (z0),
      .x_o     (x_o),
      .y_o     (y_o),
      .z_o     (z_o),
      .valid_o (valid_o),
      .busy_o  (busy_o),
      .done_o  (done_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;
   int n_valid = 0;

   typedef struct {
      bit smp;
      int x;
      int y;
      int z;
      bit done;
      int cyc;
   } exp_t;

   exp_t exp_q[$];

   task automatic check(string nm, int act, int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- reference model (plain integer arithmetic) -------------
   function automatic int floor_div(int a, int d);
      int q = a / d;
      if ((a % d) != 0 && a < 0) q = q - 1;
      return q;
   endfunction

   function automatic int clamp(int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic int abs_sat(int v);
      return (v < 0) ? clamp(-v) : v;
   endfunction

   task automatic model_step(inout int x, inout int y, inout int z);
      int dx = y;
      int dy = z;
      int dz = clamp(-floor_div(4915 * z, 8192) - y + abs_sat(x) - 8192);
      x = clamp(x + floor_div(dx, 64));
      y = clamp(y + floor_div(dy, 64));
      z = clamp(z + floor_div(dz, 64));
   endtask

   function automatic int s16(logic [15:0] v);
      return int'($signed(v));
   endfunction

   // ---------------- stimulus helpers ---------------------------------------
   task automatic drive_start(int n, int ix, int iy, int iz);
      steps = n[15:0];
      x0    = ix[15:0];
      y0    = iy[15:0];
      z0    = iz[15:0];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic issue(int n, int ix, int iy, int iz);
      int   k;
      int   x = ix;
      int   y = iy;
      int   z = iz;
      exp_t e;
      @(negedge clk);
      k = cyc + 1;
      if (n == 0) begin
         e.smp = 1'b0; e.x = ix; e.y = iy; e.z = iz; e.done = 1'b1; e.cyc = k + 1;
         exp_q.push_back(e);
      end
      for (int i = 0; i < n; i++) begin
         model_step(x, y, z);
         e.smp = 1'b1; e.x = x; e.y = y; e.z = z; e.done = (i == n - 1); e.cyc = k + 3 + 2 * i;
         exp_q.push_back(e);
      end
      drive_start(n, ix, iy, iz);
   endtask

   // Single-step run whose expected sample is given directly rather than modelled.
   task automatic issue_one(int ix, int iy, int iz, int ex, int ey, int ez);
      exp_t e;
      @(negedge clk);
      e.smp = 1'b1; e.x = ex; e.y = ey; e.z = ez; e.done = 1'b1; e.cyc = cyc + 4;
      exp_q.push_back(e);
      drive_start(1, ix, iy, iz);
   endtask

   task automatic drain(int budget);
      int t = 0;
      while (exp_q.size() != 0 && t < budget) begin
         @(negedge clk);
         t++;
      end
      check("drain_queue_empty", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
   endtask

   // ---------------- monitor -------------------------------------------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && valid_o) n_valid++;
         if (rst_n && (valid_o || done_o)) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", int'(valid_o) + 2 * int'(done_o), 0);
            end else begin
               e = exp_q.pop_front();
               check("valid_o", int'(valid_o), int'(e.smp));
               check("done_o", int'(done_o), int'(e.done));
               check("busy_o", int'(busy_o), int'(!e.done));
               check("x_o", s16(x_o), e.x);
               check("y_o", s16(y_o), e.y);
               check("z_o", s16(z_o), e.z);
               check("sample_cycle", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached, got cycle %0d, expected completion", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ------------------------------------------
   initial begin
      int v0;
      int t;
      int cnt_v;

      repeat (3) @(negedge clk);
      check("reset_x", s16(x_o), 0);
      check("reset_y", s16(y_o), 0);
      check("reset_z", s16(z_o), 0);
      check("reset_valid", int'(valid_o), 0);
      check("reset_busy", int'(busy_o), 0);
      check("reset_done", int'(done_o), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single step, hand-derived result
      issue_one(0, -5734, 0, -90, -5734, -39);
      drain(20);

      // zero steps: done only, initial conditions visible
      issue(0, 1000, -2000, 3000);
      drain(20);

      // saturation of x update and |-32768| clamp
      issue_one(32767, 32767, 0, 32767, 32767, -128);
      drain(20);
      issue_one(-32768, 0, 0, -32768, 0, 383);
      drain(20);

      // long run against the model, with an explicit pulse count
      v0 = n_valid;
      issue(1000, 0, -5734, 0);
      drain(2100);
      check("long_run_valid_count", n_valid - v0, 1000);

      // start while busy must be ignored
      issue(20, 4096, -1234, 777);
      repeat (9) @(negedge clk);
      drive_start(5, 111, 222, 333);
      drain(60);

      // randomized runs
      for (int r = 0; r < 10; r++) begin
         int n  = (r % 4 == 3) ? 0 : int'($urandom_range(1, 40));
         int ix = int'($urandom_range(0, 65535)) - 32768;
         int iy = int'($urandom_range(0, 65535)) - 32768;
         int iz = int'($urandom_range(0, 65535)) - 32768;
         issue(n, ix, iy, iz);
         drain(2 * n + 20);
      end

      // asynchronous reset mid-run, while in DERIV after a sample
      issue(50, 0, -5734, 0);
      t = 0;
      while (!valid_o && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("midrun_valid_seen", int'(valid_o), 1);
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("midrun_rst_x", s16(x_o), 0);
      check("midrun_rst_y", s16(y_o), 0);
      check("midrun_rst_z", s16(z_o), 0);
      check("midrun_rst_valid", int'(valid_o), 0);
      check("midrun_rst_busy", int'(busy_o), 0);
      check("midrun_rst_done", int'(done_o), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      cnt_v = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (valid_o || done_o || busy_o) cnt_v++;
      end
      check("post_reset_quiet", cnt_v, 0);

      // run again after reset to confirm normal operation resumes
      issue(3, -8000, 2000, -500);
      drain(30);

      check("final_queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pwl_euler_integrator.md
Name: pwl_euler_integrator

Overview:
- Forward-Euler integrator for the simplest piece-wise linear chaotic jerk system: x' = y, y' = z, z' = -A·z - y + |x| - 1.
- Sits directly downstream of the initial-condition ROM. It loads x0/y0/z0 from the ROM on start, then iterates a programmed number of steps.
- Emits one (x, y, z) sample per step to the output/DAC stage.
- Fixed-point format: signed 16 bit, 13 fractional bits (range [-4, 4)).

Parameters:
- Width, 16, word width of all state variables.
- Frac, 13, fractional bits. 1.0 = 2^Frac = 8192.
- CoefA, 16'sd4915, A = 0.6 in the same format.
- ShiftH, 6, step size h = 2^-ShiftH (1/64). The multiply by h is an arithmetic right shift.
- CntWidth, 16, width of the step counter.

Ports:
- clk_i  in  1  clock; all registers update on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  start request, sampled only in IDLE.
- steps_i  in  CntWidth  number of Euler steps to run, captured with start_i.
- x0_i, y0_i, z0_i  in  Width each  initial conditions from the ROM, captured with start_i.
- x_o, y_o, z_o  out  Width each  current state registers.
- valid_o  out  1  one-cycle pulse when a new sample is on x_o/y_o/z_o.
- busy_o  out  1  high from the LOAD state until return to IDLE.
- done_o  out  1  one-cycle pulse when the run completes.

Behaviour:
Reset (async, rst_ni=0):
- State = IDLE.
- x_o, y_o, z_o, counter and derivative registers all 0.
- valid_o, busy_o, done_o all 0.
- Takes effect immediately, including mid-run. No partial sample is emitted after reset is released.

FSM states: IDLE, LOAD, DERIV, UPDATE.
- IDLE:
  - start_i=1 → capture steps_i and x0/y0/z0, go to LOAD.
  - start_i=0 → stay in IDLE.
- LOAD:
  - x/y/z ← captured initial values.
  - Counter = 0 → done_o=1 next cycle, go to IDLE, no valid_o.
  - Otherwise → go to DERIV.
- DERIV:
  - Register dx = y, dy = z.
  - dz = sat(-(A·z) - y + abs_sat(x) - 8192).
  - Go to UPDATE.
- UPDATE:
  - x ← sat(x + (dx>>>ShiftH)); likewise y and z.
  - valid_o=1 in the following cycle. Counter decrements.
  - Counter reaches 0 → done_o pulses in the same cycle as that valid_o, go to IDLE.
  - Otherwise → go to DERIV.

Timing:
- start_i sampled at edge k → LOAD at k+1 → first valid_o high during the cycle after edge k+3.
- Sample period is 2 cycles.
- busy_o = (state != IDLE).
- start_i while busy is ignored. Captured steps and initial conditions are held until the next start in IDLE.

Arithmetic:
- A·z: full 32-bit signed product, then arithmetic right shift by Frac (floor), kept in Width+3 bits.
- abs_sat(-32768) = 32767.
- The dz sum is formed in Width+3 bits, then saturated to [-32768, 32767].
- Update shifts are arithmetic (floor toward -inf).
- Every update addition saturates. No wrap-around is permitted.

Decomposition:
- Shared package pwl_pkg holds:
  - fixed-point typedef (signed [Width-1:0]);
  - constants FRAC=13, ONE=8192, COEF_A=4915, SHIFT_H=6;
  - FSM state enum.
- One sub-module, sat_add (signed add with saturation to Width), instantiated for the four saturating sums.
- The multiply and FSM stay in the top.

Test Plan:
- Reset: assert rst_ni=0 mid-run in DERIV → outputs and flags read 0 immediately. After release, valid_o stays 0 until a new start.
- Single step: start_i=1, steps_i=1, (x0,y0,z0)=(0, -5734, 0).
  - Expected on the first valid_o: x=-90, y=-5734, z=-39.
  - done_o pulses in that same cycle, then busy_o falls.
- steps_i=0 → done_o one cycle after LOAD, no valid_o, x_o/y_o/z_o equal the loaded initial conditions.
- Run steps_i=1000 from (0, -5734, 0):
  - exactly 1000 valid_o pulses, each spaced 2 cycles apart;
  - results bit-exact against a fixed-point reference model using the same floor/saturation rules.
- Saturation: (x0,y0,z0)=(32767, 32767, 0), steps_i=1 → x_o=32767 (clamped).
- abs_sat: x0=-32768 → the dz path uses 32767.
- Start while busy: pulse start_i with new steps_i mid-run → ignored, and the original step count completes unchanged.
